// File: rtl/time_of_day_pkg.sv
// Shared definitions for the time-of-day clock: field limits, widths, segment patterns.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package time_of_day_pkg;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

    // Active-low gfedcba patterns for digits 0..9; any other code blanks the digit.
    localparam logic [6:0] SEG_DIGITS [10] = '{
        7'b1000000, // 0
        7'b1111001, // 1
        7'b0100100, // 2
        7'b0110000, // 3
        7'b0011001, // 4
        7'b0010010, // 5
        7'b0000010, // 6
        7'b1111000, // 7
        7'b0000000, // 8
        7'b0010000  // 9
    };
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Field values never exceed 63, so both quotient and remainder fit in 4 bits.
    function automatic logic [3:0] bcd_tens(input logic [5:0] v);
        return 4'(v / 6'd10);
    endfunction

    function automatic logic [3:0] bcd_ones(input logic [5:0] v);
        return 4'(v % 6'd10);
    endfunction

endpackage

// File: rtl/time_of_day_seg7_decode.sv
// One BCD digit to an active-low gfedcba seven-segment pattern; non-decimal codes blank.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: bcd - 4-bit digit in; seg - 7-bit active-low segments out.
module seg7_decode
    import time_of_day_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        for (int i = 0; i < 10; i++) begin
            if (bcd == 4'(i)) begin
                seg = SEG_DIGITS[i];
            end
        end
    end

endmodule

// File: rtl/time_of_day.sv
// Time-of-day clock: prescaled one-second tick drives hh:mm:ss, with set mode and 7-seg out.
// Latency: time_count updates one cycle after the internal tick; time_7seg is combinational.
// Backpressure: none; up requests are level inputs, edge detected internally.
// Ports: clk, reset (async, active-high); up[2:0] hour/min/sec increment requests;
//        set (1 = frozen set mode); time_count {hh,mm,ss}; clock_carry midnight pulse;
//        time_7seg six active-low digits, sec ones in the LSBs.
module time_of_day
    import time_of_day_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int TICK_W = 26
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  up,
    input  logic        set,
    output logic [16:0] time_count,
    output logic        clock_carry,
    output logic [41:0] time_7seg
);

    localparam logic [TICK_W-1:0] PRESC_LAST = TICK_W'(CLK_HZ - 1);

    logic [TICK_W-1:0] presc;
    logic [2:0]        up_q;
    logic [2:0]        up_edge;
    logic              tick;

    logic [SEC_W-1:0]  sec_q,  sec_d;
    logic [MIN_W-1:0]  min_q,  min_d;
    logic [HOUR_W-1:0] hour_q, hour_d;
    logic              rollover;
    logic              carry_q;

    // Set mode gates the tick combinationally, so a set rising on the wrap cycle wins.
    assign tick    = !set && (presc == PRESC_LAST);
    assign up_edge = up & ~up_q;

    // Prescaler is parked at 0 in set mode so leaving set mode yields a full period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (set || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + TICK_W'(1);
        end
    end

    // Edge history tracks up in both modes so run-mode activity never leaks into set mode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            up_q <= '0;
        end else begin
            up_q <= up;
        end
    end

    always_comb begin
        sec_d    = sec_q;
        min_d    = min_q;
        hour_d   = hour_q;
        rollover = 1'b0;
        if (set) begin
            // Manual adjust: each field wraps on its own, no carry between fields.
            if (up_edge[0]) sec_d  = (sec_q  == SEC_MAX)  ? '0 : sec_q  + 6'd1;
            if (up_edge[1]) min_d  = (min_q  == MIN_MAX)  ? '0 : min_q  + 6'd1;
            if (up_edge[2]) hour_d = (hour_q == HOUR_MAX) ? '0 : hour_q + 5'd1;
        end else if (tick) begin
            if (sec_q == SEC_MAX) begin
                sec_d = '0;
                if (min_q == MIN_MAX) begin
                    min_d = '0;
                    if (hour_q == HOUR_MAX) begin
                        hour_d   = '0;
                        rollover = 1'b1;
                    end else begin
                        hour_d = hour_q + 5'd1;
                    end
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end
    end

    // Carry is registered alongside the time so it is high exactly while 00:00:00 is new.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sec_q   <= '0;
            min_q   <= '0;
            hour_q  <= '0;
            carry_q <= 1'b0;
        end else begin
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            carry_q <= rollover;
        end
    end

    assign time_count  = {hour_q, min_q, sec_q};
    assign clock_carry = carry_q;

    // Digit order matches the output packing: sec ones first, hour tens last.
    logic [3:0] digit [6];

    assign digit[0] = bcd_ones(sec_q);
    assign digit[1] = bcd_tens(sec_q);
    assign digit[2] = bcd_ones(min_q);
    assign digit[3] = bcd_tens(min_q);
    assign digit[4] = bcd_ones({1'b0, hour_q});
    assign digit[5] = bcd_tens({1'b0, hour_q});

    for (genvar g = 0; g < 6; g++) begin : g_digit
        seg7_decode u_seg7_decode (
            .bcd (digit[g]),
            .seg (time_7seg[7*g +: 7])
        );
    end

endmodule

// File: tb/tb_time_of_day.sv
// Directed bench for time_of_day with a 4-cycle second.
// Latency: n/a.
// Backpressure: n/a.
module tb_time_of_day;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  up;
    logic        set;
    logic [16:0] time_count;
    logic        clock_carry;
    logic [41:0] time_7seg;

    int total = 0;
    int bad   = 0;
    int carry_cycles = 0;

    localparam logic [41:0] SEG_ZERO = {6{7'b1000000}};

    time_of_day #(.CLK_HZ(4), .TICK_W(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .up          (up),
        .set         (set),
        .time_count  (time_count),
        .clock_carry (clock_carry),
        .time_7seg   (time_7seg)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (clock_carry === 1'b1) carry_cycles++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic set_val);
        reset = 1'b1;
        set   = set_val;
        up    = 3'b000;
        step();
        reset = 1'b0;
    endtask

    task automatic pulse_up(input logic [2:0] mask, input int n);
        for (int i = 0; i < n; i++) begin
            up = mask;
            step();
            up = 3'b000;
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; set = 1'b0; up = 3'b000;
        #3;
        total++; if (time_count !== 17'd0) begin bad++; $display("FAIL reset_time actual=%h required=%h", time_count, 17'd0); end
        total++; if (clock_carry !== 1'b0) begin bad++; $display("FAIL reset_carry actual=%b required=0", clock_carry); end
        total++; if (time_7seg !== SEG_ZERO) begin bad++; $display("FAIL reset_7seg actual=%h required=%h", time_7seg, SEG_ZERO); end
        step();
    endtask

    task automatic test_run();
        apply_reset(1'b0);
        repeat (3) step();
        total++; if (time_count !== 17'd0) begin bad++; $display("FAIL run_before_tick actual=%h required=%h", time_count, 17'd0); end
        step();
        total++; if (time_count !== 17'd1) begin bad++; $display("FAIL run_first_tick actual=%h required=%h", time_count, 17'd1); end
        repeat (8) step();
        total++; if (time_count !== 17'd3) begin bad++; $display("FAIL run_12_cycles actual=%h required=%h", time_count, 17'd3); end
        total++; if (time_7seg !== {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h30}) begin bad++;
            $display("FAIL run_7seg actual=%h required=%h", time_7seg, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h30}); end
    endtask

    task automatic test_rollover();
        apply_reset(1'b1);
        pulse_up(3'b111, 23);
        pulse_up(3'b011, 36);
        total++; if (time_count !== {5'd23, 6'd59, 6'd59}) begin bad++; $display("FAIL preload_235959 actual=%h required=%h", time_count, {5'd23, 6'd59, 6'd59}); end
        total++; if (time_7seg !== {7'h24, 7'h30, 7'h12, 7'h10, 7'h12, 7'h10}) begin bad++;
            $display("FAIL preload_7seg actual=%h required=%h", time_7seg, {7'h24, 7'h30, 7'h12, 7'h10, 7'h12, 7'h10}); end
        carry_cycles = 0;
        set = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i == 3) begin
                total++; if (time_count !== {5'd23, 6'd59, 6'd59}) begin bad++; $display("FAIL rollover_hold actual=%h required=%h", time_count, {5'd23, 6'd59, 6'd59}); end
                total++; if (clock_carry !== 1'b0) begin bad++; $display("FAIL rollover_carry_early actual=%b required=0", clock_carry); end
            end
            if (i == 4) begin
                total++; if (time_count !== 17'd0) begin bad++; $display("FAIL rollover_time actual=%h required=%h", time_count, 17'd0); end
                total++; if (clock_carry !== 1'b1) begin bad++; $display("FAIL rollover_carry actual=%b required=1", clock_carry); end
                total++; if (time_7seg !== SEG_ZERO) begin bad++; $display("FAIL rollover_7seg actual=%h required=%h", time_7seg, SEG_ZERO); end
            end
            if (i == 5) begin
                total++; if (clock_carry !== 1'b0) begin bad++; $display("FAIL rollover_carry_late actual=%b required=0", clock_carry); end
            end
        end
        total++; if (carry_cycles !== 1) begin bad++; $display("FAIL rollover_carry_width actual=%0d required=1", carry_cycles); end
    endtask

    task automatic test_set_wrap();
        apply_reset(1'b1);
        pulse_up(3'b001, 59);
        total++; if (time_count !== 17'd59) begin bad++; $display("FAIL set_sec_59 actual=%h required=%h", time_count, 17'd59); end
        carry_cycles = 0;
        pulse_up(3'b001, 1);
        total++; if (time_count !== 17'd0) begin bad++; $display("FAIL set_sec_wrap actual=%h required=%h", time_count, 17'd0); end
        pulse_up(3'b100, 23);
        total++; if (time_count !== {5'd23, 12'd0}) begin bad++; $display("FAIL set_hour_23 actual=%h required=%h", time_count, {5'd23, 12'd0}); end
        pulse_up(3'b100, 1);
        total++; if (time_count !== 17'd0) begin bad++; $display("FAIL set_hour_wrap actual=%h required=%h", time_count, 17'd0); end
        total++; if (carry_cycles !== 0) begin bad++; $display("FAIL set_no_carry actual=%0d required=0", carry_cycles); end
        pulse_up(3'b111, 1);
        total++; if (time_count !== {5'd1, 6'd1, 6'd1}) begin bad++; $display("FAIL set_simultaneous actual=%h required=%h", time_count, {5'd1, 6'd1, 6'd1}); end
    endtask

    task automatic test_hold();
        // Starts from 01:01:01 in set mode, left by test_set_wrap.
        up = 3'b010;
        repeat (10) step();
        up = 3'b000;
        step();
        total++; if (time_count !== {5'd1, 6'd2, 6'd1}) begin bad++; $display("FAIL hold_one_step actual=%h required=%h", time_count, {5'd1, 6'd2, 6'd1}); end
        set = 1'b0;
        pulse_up(3'b010, 1);
        total++; if (time_count !== {5'd1, 6'd2, 6'd1}) begin bad++; $display("FAIL run_ignores_up actual=%h required=%h", time_count, {5'd1, 6'd2, 6'd1}); end
        repeat (2) step();
        total++; if (time_count !== {5'd1, 6'd2, 6'd2}) begin bad++; $display("FAIL run_after_set actual=%h required=%h", time_count, {5'd1, 6'd2, 6'd2}); end
    endtask

    task automatic test_async_reset();
        apply_reset(1'b1);
        pulse_up(3'b111, 12);
        pulse_up(3'b011, 22);
        pulse_up(3'b001, 22);
        total++; if (time_count !== {5'd12, 6'd34, 6'd56}) begin bad++; $display("FAIL preload_123456 actual=%h required=%h", time_count, {5'd12, 6'd34, 6'd56}); end
        total++; if (time_7seg !== {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}) begin bad++;
            $display("FAIL preload_123456_7seg actual=%h required=%h", time_7seg, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}); end
        set = 1'b0;
        repeat (2) step();
        #2;
        reset = 1'b1;
        #1;
        total++; if (time_count !== 17'd0) begin bad++; $display("FAIL async_reset_time actual=%h required=%h", time_count, 17'd0); end
        total++; if (time_7seg !== SEG_ZERO) begin bad++; $display("FAIL async_reset_7seg actual=%h required=%h", time_7seg, SEG_ZERO); end
        step();
        reset = 1'b0;

        // Reset landing while a midnight rollover is one edge away.
        apply_reset(1'b1);
        pulse_up(3'b111, 23);
        pulse_up(3'b011, 36);
        set = 1'b0;
        repeat (3) step();
        carry_cycles = 0;
        #2;
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (6) step();
        total++; if (carry_cycles !== 0) begin bad++; $display("FAIL reset_cancels_carry actual=%0d required=0", carry_cycles); end
        total++; if (time_count !== 17'd1) begin bad++; $display("FAIL reset_then_run actual=%h required=%h", time_count, 17'd1); end
    endtask

    task automatic test_set_priority();
        apply_reset(1'b0);
        repeat (3) step();
        total++; if (time_count !== 17'd0) begin bad++; $display("FAIL prio_before actual=%h required=%h", time_count, 17'd0); end
        set = 1'b1;
        step();
        total++; if (time_count !== 17'd0) begin bad++; $display("FAIL prio_tick_suppressed actual=%h required=%h", time_count, 17'd0); end
        step();
        set = 1'b0;
        repeat (3) step();
        total++; if (time_count !== 17'd0) begin bad++; $display("FAIL prio_restart_early actual=%h required=%h", time_count, 17'd0); end
        step();
        total++; if (time_count !== 17'd1) begin bad++; $display("FAIL prio_restart_tick actual=%h required=%h", time_count, 17'd1); end
    endtask

    initial begin
        test_reset();
        test_run();
        test_rollover();
        test_set_wrap();
        test_hold();
        test_async_reset();
        test_set_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
